// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PULSE,
        WAIT,
        STABLE,
        RUN,
        FAIL
    } state_t;

    localparam int unsigned RETRY_W = 4;
    localparam int unsigned LOSS_W  = 8;

    // Increment that holds at lim instead of wrapping.
    function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v,
                                                  input logic [LOSS_W-1:0] lim);
        return (v >= lim) ? v : v + LOSS_W'(1);
    endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// Two-stage synchronizer, cleared to zero by synchronous rst.
module pll_sup_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for stable lock, releases sys_reset.
// Define PLL_SUP_LOSS_FILTER_EN to require LOSS_FILTER consecutive unlocked cycles in RUN.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT     = 50000,
    parameter int unsigned LOCK_STABLE      = 1024,
    parameter int unsigned MAX_RETRIES      = 7,
    parameter int unsigned LOSS_FILTER      = 8
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              locked,
    output logic              pll_rst,
    output logic              sys_reset,
    output logic              ready,
    output logic              fail,
    output logic [RETRY_W-1:0] retry_count,
    output logic [LOSS_W-1:0]  loss_count
);

    localparam int unsigned CNT_MAX0 = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES
                                                                         : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > LOCK_STABLE) ? CNT_MAX0 : LOCK_STABLE;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned FLT_W    = $clog2(LOSS_FILTER + 1);

`ifdef PLL_SUP_LOSS_FILTER_EN
    localparam int unsigned LOSS_N = LOSS_FILTER;
`else
    // Threshold of one: the filter counter stays at zero and every unlocked cycle is a loss.
    localparam int unsigned LOSS_N = 1;
`endif

    localparam logic [CNT_W-1:0]  PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [FLT_W-1:0]  LOSS_LAST    = FLT_W'(LOSS_N - 1);
    localparam logic [LOSS_W-1:0] RETRY_LIM    = LOSS_W'((1 << RETRY_W) - 1);
    localparam logic [LOSS_W-1:0] LOSS_LIM     = '1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [FLT_W-1:0]   flt;
    logic               lk_s;
    logic [RETRY_W-1:0] retry_inc;
    logic               retry_fail;

    pll_sup_sync #(.WIDTH(1)) u_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (lk_s)
    );

    assign retry_inc  = RETRY_W'(sat_inc(LOSS_W'(retry_count), RETRY_LIM));
    assign retry_fail = (MAX_RETRIES != 0) && (32'(retry_inc) >= MAX_RETRIES);

    // Sequencer; outputs are updated on the transition into each state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= PULSE;
            cnt         <= '0;
            flt         <= '0;
            pll_rst     <= 1'b1;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
            fail        <= 1'b0;
            retry_count <= '0;
            loss_count  <= '0;
        end else begin
            unique case (state)
                PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        state   <= WAIT;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT: begin
                    // Lock takes priority over a coincident timeout.
                    if (lk_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        retry_count <= retry_inc;
                        cnt         <= '0;
                        pll_rst     <= 1'b1;
                        if (retry_fail) begin
                            state <= FAIL;
                            fail  <= 1'b1;
                        end else begin
                            state <= PULSE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!lk_s) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state     <= RUN;
                        cnt       <= '0;
                        sys_reset <= 1'b0;
                        ready     <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (lk_s) begin
                        flt <= '0;
                    end else if (flt == LOSS_LAST) begin
                        flt        <= '0;
                        loss_count <= sat_inc(loss_count, LOSS_LIM);
                        state      <= PULSE;
                        cnt        <= '0;
                        pll_rst    <= 1'b1;
                        sys_reset  <= 1'b1;
                        ready      <= 1'b0;
                    end else begin
                        flt <= flt + FLT_W'(1);
                    end
                end
                FAIL: begin
                    state <= FAIL;
                end
                default: begin
                    state <= PULSE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: output transitions are matched against queued expectations.
module tb_pll_lock_supervisor;

    localparam int unsigned PULSE_N = 4;
    localparam int unsigned TO_N    = 20;
    localparam int unsigned STAB_N  = 8;
    localparam int unsigned PER     = PULSE_N + TO_N;

    // Output vector order: {pll_rst, sys_reset, ready, fail}
    localparam logic [3:0] V_WAIT = 4'b0100;
    localparam logic [3:0] V_PULS = 4'b1100;
    localparam logic [3:0] V_RUN  = 4'b0010;
    localparam logic [3:0] V_FAIL = 4'b1101;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  val;
    } exp_t;

    logic       refclk;
    logic       rst;
    logic       locked;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       fail;
    logic [3:0] retry_count;
    logic [7:0] loss_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned base;
    int unsigned mark;
    logic        mon_en = 1'b0;
    logic [3:0]  mon_prev;
    logic [3:0]  mon_vec;
    exp_t        q[$];

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES (PULSE_N),
        .LOCK_TIMEOUT     (TO_N),
        .LOCK_STABLE      (STAB_N),
        .MAX_RETRIES      (3),
        .LOSS_FILTER      (3)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .pll_rst     (pll_rst),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .fail        (fail),
        .retry_count (retry_count),
        .loss_count  (loss_count)
    );

    initial refclk = 1'b0;
    always #10 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Every output change is matched in order against the expectation queue.
    always @(negedge refclk) begin
        mon_vec = {pll_rst, sys_reset, ready, fail};
        if (mon_en && mon_vec !== mon_prev) begin
            if (q.size() == 0) begin
                check("spurious_change", 32'(mon_vec), 32'(mon_prev));
            end else begin
                exp_t e;
                e = q.pop_front();
                check("evt_cycle", 32'(cyc), 32'(e.cyc));
                check("evt_value", 32'(mon_vec), 32'(e.val));
            end
        end
        mon_prev = mon_vec;
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic expect_at(input int unsigned c, input logic [3:0] v);
        q.push_back('{cyc: c, val: v});
    endtask

    task automatic wait_drain(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while (q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_drain"}, 32'(q.size()), 32'd0);
    endtask

    // Holds rst for two edges, checks reset values after the first, leaves base at the last rst edge.
    task automatic do_reset(input string tag);
        mon_en = 1'b0;
        rst    = 1'b1;
        locked = 1'b0;
        tick(1);
        check({tag, "_rst_vec"}, 32'({pll_rst, sys_reset, ready, fail}), 32'(V_PULS));
        check({tag, "_rst_retry"}, 32'(retry_count), 32'd0);
        check({tag, "_rst_loss"}, 32'(loss_count), 32'd0);
        tick(1);
        rst    = 1'b0;
        mon_en = 1'b1;
        base   = cyc;
    endtask

    initial begin
        rst    = 1'b1;
        locked = 1'b0;
        tick(2);

        // S1: first lock, raised 5 cycles after pll_rst falls
        do_reset("s1");
        expect_at(base + PULSE_N, V_WAIT);
        tick(PULSE_N - 1);
        check("s1_pulse_held", 32'(pll_rst), 32'd1);
        tick(1 + 5);
        locked = 1'b1;
        expect_at(cyc + 2 + STAB_N + 1, V_RUN);
        wait_drain("s1", 40);
        check("s1_ready", 32'(ready), 32'd1);
        check("s1_retry", 32'(retry_count), 32'd0);

        // S4: loss of lock while running
`ifdef PLL_SUP_LOSS_FILTER_EN
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(10);
        check("s4_glitch_loss", 32'(loss_count), 32'd0);
        mark = cyc;
        locked = 1'b0;
        tick(3);
        locked = 1'b1;
        expect_at(mark + 5, V_PULS);
        expect_at(mark + 5 + PULSE_N, V_WAIT);
        expect_at(mark + 5 + PULSE_N + 1 + STAB_N, V_RUN);
`else
        mark = cyc;
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        expect_at(mark + 3, V_PULS);
        expect_at(mark + 3 + PULSE_N, V_WAIT);
        expect_at(mark + 3 + PULSE_N + 1 + STAB_N, V_RUN);
`endif
        wait_drain("s4", 40);
        check("s4_loss", 32'(loss_count), 32'd1);
        check("s4_retry", 32'(retry_count), 32'd0);

        // S3: one-cycle unlock at STABLE count 5 restarts the stability window
        do_reset("s3");
        expect_at(base + PULSE_N, V_WAIT);
        tick(PULSE_N + 5);
        mark = cyc;
        locked = 1'b1;
        tick(6);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        expect_at(mark + 18, V_RUN);
        wait_drain("s3", 40);
        check("s3_loss", 32'(loss_count), 32'd0);
        check("s3_ready", 32'(ready), 32'd1);

        // S2: never locks -> three pulses then terminal FAIL
        do_reset("s2");
        for (int k = 0; k < 3; k++) begin
            expect_at(base + PULSE_N + PER * k, V_WAIT);
            expect_at(base + PER * (k + 1), (k == 2) ? V_FAIL : V_PULS);
        end
        wait_drain("s2", 120);
        check("s2_retry", 32'(retry_count), 32'd3);
        check("s2_fail", 32'(fail), 32'd1);
        locked = 1'b1;
        tick(30);
        check("s2_fail_sticky", 32'({pll_rst, sys_reset, ready, fail}), 32'(V_FAIL));
        check("s2_retry_hold", 32'(retry_count), 32'd3);

        // S5: rst in WAIT after two retries
        do_reset("s5");
        expect_at(base + PULSE_N, V_WAIT);
        expect_at(base + PER, V_PULS);
        expect_at(base + PER + PULSE_N, V_WAIT);
        expect_at(base + 2 * PER, V_PULS);
        expect_at(base + 2 * PER + PULSE_N, V_WAIT);
        tick(2 * PER + PULSE_N + 8);
        wait_drain("s5", 10);
        check("s5_retry_pre", 32'(retry_count), 32'd2);
        check("s5_in_wait", 32'(pll_rst), 32'd0);
        do_reset("s5_mid");

        // S6: lk_s rises on the timeout cycle; lock wins
        expect_at(base + PULSE_N, V_WAIT);
        expect_at(base + PER + STAB_N, V_RUN);
        tick(PER - 3);
        locked = 1'b1;
        wait_drain("s6", 60);
        check("s6_retry", 32'(retry_count), 32'd0);
        check("s6_ready", 32'(ready), 32'd1);
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Initiator side of the PLL reset/lock interface. Runs on the free-running 50 MHz reference clock and drives the PLL reset pulse. It watches the PLL's asynchronous locked output and releases the system reset only after lock has been stable for a set time. On lock timeout it retries the PLL reset, and on loss of lock it re-asserts system reset and restarts the sequence.

Parameters:
RST_PULSE_CYCLES, 16, refclk cycles pll_rst is held high per attempt (>=1)
LOCK_TIMEOUT, 50000, refclk cycles to wait for lock before retry (1 ms @ 50 MHz)
LOCK_STABLE, 1024, consecutive synced-locked cycles required before release
MAX_RETRIES, 7, failed attempts allowed before FAIL; 0 = retry forever
LOSS_FILTER, 8, loss-of-lock filter length (used only with the optional feature)

Ports:
refclk  in  1  reference clock, 50 MHz, sole clock
rst  in  1  synchronous active-high reset
locked  in  1  PLL lock, asynchronous to refclk
pll_rst  out  1  reset to PLL, active high
sys_reset  out  1  system reset, active high
ready  out  1  high while in RUN
fail  out  1  sticky high in FAIL
retry_count  out  4  failed lock attempts since rst, saturating at 15
loss_count  out  8  loss-of-lock events since rst, saturating at 255

Behaviour:
- Interface: one clock (refclk); reset rst is synchronous and active-high.
- locked passes through a 2-FF synchronizer to give lk_s. The state machine sees lk_s only, so its latency is 2 cycles.
- Reset values: pll_rst=1, sys_reset=1, ready=0, fail=0, retry_count=0, loss_count=0, state=PULSE, counters=0.
- PULSE:
  - pll_rst=1, sys_reset=1.
  - Count RST_PULSE_CYCLES cycles, then go to WAIT and clear the counter.
- WAIT:
  - pll_rst=0, sys_reset=1.
  - If lk_s=1, go to STABLE with the counter at 0.
  - If the counter reaches LOCK_TIMEOUT-1 with lk_s=0, retry_count++ (saturating).
    - If MAX_RETRIES!=0 and the new count >= MAX_RETRIES, go to FAIL.
    - Otherwise go to PULSE.
- STABLE:
  - sys_reset=1.
  - Any lk_s=0 cycle clears the counter and returns to WAIT. The WAIT timeout restarts; this is not counted as a retry.
  - After LOCK_STABLE consecutive lk_s=1 cycles, go to RUN.
- RUN:
  - sys_reset=0 and ready=1, both registered, on the first cycle in RUN.
  - Loss of lock (lk_s=0, or filtered loss when the optional feature is enabled):
    - loss_count++ (saturating);
    - sys_reset=1 and ready=0 on the next cycle;
    - go to PULSE.
- FAIL:
  - pll_rst=1, sys_reset=1, fail=1.
  - Terminal state; only rst exits it.
- Outputs are all registered, with no combinational path from locked.
- rst mid-sequence: every state returns to reset values on the next edge, and both counts clear.
- Simultaneous timeout and lk_s rising in WAIT: lock wins, go to STABLE.
- Counter widths are $clog2 of the max parameter +1. Counters do not wrap; they compare and clear.

Optional Feature:
- Macro: PLL_SUP_LOSS_FILTER_EN.
- Defined: in RUN, loss of lock is declared only after LOSS_FILTER consecutive lk_s=0 cycles. Any lk_s=1 clears the filter counter. sys_reset follows one cycle after the declaration.
- Undefined: a single lk_s=0 cycle in RUN is a loss event. The LOSS_FILTER parameter is ignored.

Decomposition:
- Package pll_sup_pkg holds:
  - the state enum (PULSE, WAIT, STABLE, RUN, FAIL);
  - the count widths (RETRY_W=4, LOSS_W=8);
  - the saturating-increment function.
- Sub-module pll_sup_sync: 2-stage synchronizer, parameterised width, reset to 0 via rst.

Test Plan (RST_PULSE_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=3, LOSS_FILTER=3):
1. Release rst and raise locked 5 cycles after pll_rst falls, held high.
   - pll_rst high for 4 cycles after rst drops.
   - sys_reset falls exactly 2+8+1 cycles after locked rises; ready=1; retry_count=0.
2. Hold locked=0 permanently.
   - Three pll_rst pulses, each 4 cycles, spaced by 20-cycle waits.
   - retry_count=3, fail=1, pll_rst and sys_reset stuck at 1.
3. Toggle locked low for 1 cycle at STABLE count 5.
   - Stability restarts; sys_reset falls 8 clean cycles later; loss_count=0.
4. After RUN, drop locked for 1 cycle.
   - Without the macro: loss_count=1, sys_reset=1, pll_rst pulse of 4 cycles, then normal relock.
   - With the macro: no reaction.
   - With the macro and 3 low cycles: loss_count=1, sys_reset=1.
5. Assert rst mid-WAIT with retry_count=2.
   - Next cycle: all reset values, retry_count=0, pll_rst=1.
6. Lock timeout and lk_s rise on the same cycle.
   - State goes to STABLE; retry_count unchanged.
